alu_accumulator: RTL

Parametrised accumulator ALU with a power/run state machine. It replaces the fixed 8-bit datapath with a WIDTH-bit one and adds three things: a valid/ready operand handshake, an iterative shift-add multiplier that takes several cycles, and a sticky overflow error that software clears explicitly. It sits between the operand source and the result consumer, holding the running accumulator value.

---
 rtl/alu_accumulator_if.sv | 11 +
 rtl/alu_accumulator.sv | 89 ++++++++
 2 files changed

// File: rtl/alu_accumulator_if.sv
// alu_accumulator_if: operand request channel and accumulator result bus
interface alu_accumulator_if #(parameter int WIDTH = 8);
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] acc;
    logic             result_valid;
    modport master (output op_valid, op, operand, input op_ready, acc, result_valid);
    modport slave  (input op_valid, op, operand, output op_ready, acc, result_valid);
endinterface

// File: rtl/alu_accumulator.sv
// alu_accumulator: WIDTH-bit accumulator ALU with op handshake, shift-add multiplier and sticky overflow
module alu_accumulator #(parameter int WIDTH = 8) (
    input  logic            clk,
    input  logic            rst,
    input  logic            on,
    input  logic            clear_err,
    output logic            overflow,
    output logic [1:0]      state,
    alu_accumulator_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {OFF = 2'b00, READY = 2'b01, RUN = 2'b10, ERROR = 2'b11} st_t;
    st_t                st;
    logic [WIDTH-1:0]   acc, mcand, alu, mask;
    logic [2*WIDTH-1:0] prod, prod_nx, addend;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     add, sub;
    logic               ov, rv, mbit;
    assign state            = st;
    assign bus.op_ready     = st == READY && on;
    assign bus.acc          = acc;
    assign bus.result_valid = rv;
    assign add              = {1'b0, acc} + {1'b0, bus.operand};
    assign sub              = {1'b0, acc} - {1'b0, bus.operand};
    // counter runs WIDTH..1, selecting multiplier bits LSB first from the held acc
    assign mask             = {{(WIDTH-1){1'b0}}, 1'b1} << (CW'(WIDTH) - cnt);
    assign mbit             = |(acc & mask);
    assign addend           = mbit ? ({{WIDTH{1'b0}}, mcand} << (CW'(WIDTH) - cnt)) : {(2*WIDTH){1'b0}};
    assign prod_nx          = prod + addend;
    // single-cycle op result and its overflow condition
    always_comb begin
        alu = bus.operand;
        ov  = 1'b0;
        case (bus.op)
            3'b000:  alu = acc & bus.operand;
            3'b001:  alu = acc | bus.operand;
            3'b010:  alu = acc ^ bus.operand;
            3'b011:  alu = ~acc;
            3'b100:  begin alu = add[WIDTH-1:0]; ov = add[WIDTH]; end
            3'b101:  begin alu = sub[WIDTH-1:0]; ov = sub[WIDTH]; end
            default: alu = bus.operand;
        endcase
    end
    // power/run state machine with accumulator, multiplier and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= OFF;
            acc      <= '0;
            overflow <= 1'b0;
            rv       <= 1'b0;
            cnt      <= '0;
            mcand    <= '0;
            prod     <= '0;
        end else begin
            rv <= 1'b0;
            if (!on) st <= OFF;
            else case (st)
                OFF:   st <= READY;
                READY: if (bus.op_valid) begin
                    if (bus.op == 3'b110) begin
                        st    <= RUN;
                        mcand <= bus.operand;
                        prod  <= '0;
                        cnt   <= CW'(WIDTH);
                    end else begin
                        acc      <= alu;
                        overflow <= ov;
                        rv       <= 1'b1;
                        st       <= ov ? ERROR : READY;
                    end
                end
                RUN: begin
                    prod <= prod_nx;
                    cnt  <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        acc      <= prod_nx[WIDTH-1:0];
                        overflow <= |prod_nx[2*WIDTH-1:WIDTH];
                        rv       <= 1'b1;
                        st       <= |prod_nx[2*WIDTH-1:WIDTH] ? ERROR : READY;
                    end
                end
                ERROR: if (clear_err) begin
                    st       <= READY;
                    overflow <= 1'b0;
                end
            endcase
        end
    end
endmodule
